// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: aligns one access at a time onto a full-width data bus,
// with a request/response handshake, bus wait states, flush and load-data extension.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [4:0]              req_rd,
    input  logic                    flush,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [4:0]              rsp_rd,
    output logic [1:0]              rsp_err,
    output logic                    bus_valid,
    input  logic                    bus_ready,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic                    bus_we,
    output logic [DATA_WIDTH/8-1:0] bus_strb,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    bus_rvalid,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    input  logic                    bus_err,
    output logic                    busy
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam logic [1:0] MAX_SIZE = 2'(OFFW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    // Access wider than the bus, or address not a multiple of the access size.
    function automatic logic req_illegal(input logic [1:0] size, input logic [2:0] addr_lo);
        logic [2:0] low_mask;
        low_mask = 3'((4'd1 << size) - 4'd1);
        return (size > MAX_SIZE) || ((addr_lo & low_mask) != 3'd0);
    endfunction

    function automatic logic [NB-1:0] lane_strb(input logic [1:0] size, input logic [OFFW-1:0] off);
        logic [NB-1:0] s;
        int            n;
        n = 32'sd1 << size;
        for (int b = 0; b < NB; b++) begin
            s[b] = (b >= int'(off)) && (b < int'(off) + n);
        end
        return s;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [1:0] size);
        logic [DATA_WIDTH-1:0] m;
        for (int b = 0; b < NB; b++) begin
            m[8*b +: 8] = (b < (32'sd1 << size)) ? 8'hFF : 8'h00;
        end
        return m;
    endfunction

    // Bring the addressed lanes down to bit 0, then fill the upper bytes with sign or zero.
    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [DATA_WIDTH-1:0] rdata,
        input logic [OFFW-1:0]       off,
        input logic [1:0]            size,
        input logic                  uns
    );
        logic [DATA_WIDTH-1:0] sh;
        logic [DATA_WIDTH-1:0] res;
        logic                  sign;
        sh = rdata >> {off, 3'b000};
        case (size)
            2'd0:    sign = sh[7];
            2'd1:    sign = sh[15];
            2'd2:    sign = sh[31];
            default: sign = sh[DATA_WIDTH-1];
        endcase
        sign = sign & ~uns;
        for (int b = 0; b < NB; b++) begin
            res[8*b +: 8] = (b < (32'sd1 << size)) ? sh[8*b +: 8] : {8{sign}};
        end
        return res;
    endfunction

    state_t                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    bus_valid_q, bus_valid_d;
    logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
    logic                    bus_we_q, bus_we_d;
    logic [NB-1:0]           bus_strb_q, bus_strb_d;
    logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [OFFW-1:0]         off_q, off_d;
    logic [4:0]              rd_q, rd_d;
    logic                    kill_q, kill_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [4:0]              rsp_rd_q, rsp_rd_d;
    logic [1:0]              rsp_err_q, rsp_err_d;
    logic                    accept_s;
    logic                    illegal_s;
    logic                    drop_s;
    logic [OFFW-1:0]         off_s;

    // Next-state and next-output computation for the IDLE/ADDR/DATA sequencer.
    always_comb begin
        state_d     = state_q;
        bus_valid_d = bus_valid_q;
        bus_addr_d  = bus_addr_q;
        bus_we_d    = bus_we_q;
        bus_strb_d  = bus_strb_q;
        bus_wdata_d = bus_wdata_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        rd_d        = rd_q;
        kill_d      = kill_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_rd_d    = rsp_rd_q;
        rsp_err_d   = rsp_err_q;
        off_s       = req_addr[OFFW-1:0];
        accept_s    = req_valid && (state_q == S_IDLE) && !flush;
        illegal_s   = req_illegal(req_size, req_addr[2:0]);
        drop_s      = kill_q || flush;

        case (state_q)
            S_IDLE: begin
                if (accept_s && illegal_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 2'b01;
                    rsp_rdata_d = {DATA_WIDTH{1'b0}};
                    rsp_rd_d    = req_rd;
                end else if (accept_s) begin
                    state_d     = S_ADDR;
                    bus_valid_d = 1'b1;
                    bus_addr_d  = {req_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
                    bus_strb_d  = lane_strb(req_size, off_s);
                    bus_wdata_d = (req_wdata & byte_mask(req_size)) << {off_s, 3'b000};
                    bus_we_d    = req_we;
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    off_d       = off_s;
                    rd_d        = req_rd;
                    kill_d      = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                if (bus_ready) begin
                    // A flush landing on the handshake still owes the bus its data beat.
                    state_d     = S_DATA;
                    bus_valid_d = 1'b0;
                    kill_d      = flush;
                end else if (flush) begin
                    state_d     = S_IDLE;
                    bus_valid_d = 1'b0;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_DATA: begin
                if (bus_rvalid && !drop_s) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rd_d    = rd_q;
                    rsp_err_d   = {bus_err, 1'b0};
                    rsp_rdata_d = (bus_err || bus_we_q) ? {DATA_WIDTH{1'b0}}
                                                        : load_extend(bus_rdata, off_q, size_q, uns_q);
                end else if (bus_rvalid) begin
                    state_d = S_IDLE;
                end else begin
                    kill_d = drop_s;
                end
            end
            default: begin
                state_d     = S_IDLE;
                bus_valid_d = 1'b0;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= {ADDR_WIDTH{1'b0}};
            bus_we_q    <= 1'b0;
            bus_strb_q  <= {NB{1'b0}};
            bus_wdata_q <= {DATA_WIDTH{1'b0}};
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            off_q       <= {OFFW{1'b0}};
            rd_q        <= 5'd0;
            kill_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_WIDTH{1'b0}};
            rsp_rd_q    <= 5'd0;
            rsp_err_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            bus_valid_q <= bus_valid_d;
            bus_addr_q  <= bus_addr_d;
            bus_we_q    <= bus_we_d;
            bus_strb_q  <= bus_strb_d;
            bus_wdata_q <= bus_wdata_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            kill_q      <= kill_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign bus_valid = bus_valid_q;
    assign bus_addr  = bus_addr_q;
    assign bus_we    = bus_we_q;
    assign bus_strb  = bus_strb_q;
    assign bus_wdata = bus_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_err   = rsp_err_q;

endmodule
